// File: rtl/block_assembler.sv
// rtl/block_assembler.sv - packs 16 received bytes into a 128-bit block and hands it to the block FIFO
module block_assembler #(
  parameter int WRITE_GAP      = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         fifo_full,
  input  logic         clear_err,
  output logic [127:0] block_out,
  output logic         write_en,
  output logic [3:0]   byte_cnt,
  output logic         pending,
  output logic         overrun_err,
  output logic         timeout_err
);

  // Gap counter only ever holds WRITE_GAP-1 down to 0.
  localparam int GW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
  localparam logic [GW-1:0]   GAP_LOAD = GW'(WRITE_GAP - 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [119:0]    shift;
  logic [GW-1:0]   gap_cnt;
  logic [TO_W-1:0] to_cnt;

  logic complete;
  logic accept_block;
  logic drop_block;
  logic to_fire;

  // The 16th byte completes a block; it is kept only if the output side is free.
  assign complete     = rx_valid && (byte_cnt == 4'd15);
  assign accept_block = complete && (state == IDLE);
  assign drop_block   = complete && (state != IDLE);
  // A byte arriving in the same cycle always beats the timeout.
  assign to_fire      = !rx_valid && (byte_cnt != 4'd0) && (to_cnt == TO_LIMIT);

  // Output state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output next-state logic: hold until the FIFO has room, strobe once, then keep din steady.
  always_comb begin
    state_nxt = state;
    write_en  = 1'b0;
    pending   = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept_block) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!fifo_full) begin
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        write_en  = 1'b1;
        state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Settle-window counter: loaded during the strobe, counts down through GAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (state == STROBE) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Byte collector: big-endian shift register and position within the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift    <= '0;
      byte_cnt <= 4'd0;
    end else if (rx_valid) begin
      shift    <= {shift[111:0], rx_data};
      byte_cnt <= byte_cnt + 4'd1;
    end else if (to_fire) begin
      shift    <= '0;
      byte_cnt <= 4'd0;
    end
  end

  // Completed block register; left untouched while a previous block is still pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      block_out <= '0;
    end else if (accept_block) begin
      block_out <= {shift, rx_data};
    end
  end

  // Inter-byte idle counter; saturates at the limit until the partial block is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (rx_valid || (byte_cnt == 4'd0)) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LIMIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Sticky error flags; a new error event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop_block) begin
        overrun_err <= 1'b1;
      end else if (clear_err) begin
        overrun_err <= 1'b0;
      end
      if (to_fire) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_block_assembler.sv
// tb/tb_block_assembler.sv - directed self-checking bench for block_assembler
module tb_block_assembler;

  localparam int WG = 4;
  localparam int TO = 20;

  logic         clk;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         fifo_full;
  logic         clear_err;
  logic [127:0] block_out;
  logic         write_en;
  logic [3:0]   byte_cnt;
  logic         pending;
  logic         overrun_err;
  logic         timeout_err;

  int checks;
  int failures;

  int           cyc;
  int           we_cnt;
  int           we_last;
  int           we_prev;
  int           stab;
  logic [127:0] held_blk;
  logic         stab_bad;

  block_assembler #(
    .WRITE_GAP(WG),
    .TIMEOUT_CYCLES(TO),
    .TO_W(17)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .fifo_full(fifo_full),
    .clear_err(clear_err),
    .block_out(block_out),
    .write_en(write_en),
    .byte_cnt(byte_cnt),
    .pending(pending),
    .overrun_err(overrun_err),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-strobe monitor: counts pulses, records their cycle, and watches din stability afterwards.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      stab <= 0;
    end else if (write_en) begin
      we_cnt   <= we_cnt + 1;
      we_prev  <= we_last;
      we_last  <= cyc;
      held_blk <= block_out;
      stab     <= WG;
    end else if (stab > 0) begin
      if (block_out !== held_blk) stab_bad <= 1'b1;
      stab <= stab - 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_bytes(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = start + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  int   we0;
  logic ok;

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    we_cnt    = 0;
    we_last   = 0;
    we_prev   = 0;
    stab      = 0;
    held_blk  = '0;
    stab_bad  = 1'b0;
    reset     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    fifo_full = 1'b0;
    clear_err = 1'b0;

    step(3);
    check("rst_block", block_out, 128'h0);
    check("rst_we", write_en, 1'b0);
    check("rst_pend", pending, 1'b0);
    check("rst_cnt", byte_cnt, 4'd0);
    check("rst_errs", {overrun_err, timeout_err}, 2'b00);
    reset = 1'b1;
    step(2);

    // 1: basic block, latency and settle window
    we0 = we_cnt;
    send_bytes(8'h00, 16);
    check("t1_block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_cnt", byte_cnt, 4'd0);
    check("t1_pend", pending, 1'b1);
    check("t1_we_early", write_en, 1'b0);
    step();
    check("t1_we", write_en, 1'b1);
    step(4);
    check("t1_pend_hold", pending, 1'b1);
    check("t1_we_off", write_en, 1'b0);
    step();
    check("t1_pend_fall", pending, 1'b0);
    check("t1_we_count", we_cnt - we0, 1);

    // 2: FIFO full holds the block
    we0 = we_cnt;
    fifo_full = 1'b1;
    send_bytes(8'h40, 16);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (write_en !== 1'b0 || block_out !== 128'h404142434445464748494A4B4C4D4E4F) ok = 1'b0;
      step();
    end
    check("t2_held_quiet", ok, 1'b1);
    check("t2_no_we", we_cnt - we0, 0);
    fifo_full = 1'b0;
    step();
    check("t2_we_release", write_en, 1'b1);
    check("t2_block", block_out, 128'h404142434445464748494A4B4C4D4E4F);
    step(6);
    check("t2_pend", pending, 1'b0);

    // 3: overrun drops the second block
    we0 = we_cnt;
    fifo_full = 1'b1;
    send_bytes(8'h10, 32);
    check("t3_overrun", overrun_err, 1'b1);
    check("t3_block", block_out, 128'h101112131415161718191A1B1C1D1E1F);
    check("t3_pend", pending, 1'b1);
    check("t3_cnt", byte_cnt, 4'd0);
    fifo_full = 1'b0;
    step();
    check("t3_we", write_en, 1'b1);
    step(6);
    check("t3_we_count", we_cnt - we0, 1);
    check("t3_pend_fall", pending, 1'b0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t3_clear", overrun_err, 1'b0);
    check("t3_no_timeout", timeout_err, 1'b0);

    // 4: timeout discards a partial block, then realigns
    send_bytes(8'h55, 5);
    check("t4_cnt5", byte_cnt, 4'd5);
    step(TO);
    check("t4_not_yet", {byte_cnt, timeout_err}, {4'd5, 1'b0});
    step(2);
    check("t4_cnt0", byte_cnt, 4'd0);
    check("t4_timeout", timeout_err, 1'b1);
    send_bytes(8'hA0, 16);
    check("t4_block", block_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    step(7);
    check("t4_pend", pending, 1'b0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t4_clear", timeout_err, 1'b0);

    // 5: back-to-back bytes, two strobes 16 cycles apart
    we0 = we_cnt;
    stab_bad = 1'b0;
    send_bytes(8'h60, 40);
    step(2);
    check("t5_we_count", we_cnt - we0, 2);
    check("t5_spacing", we_last - we_prev, 16);
    check("t5_stable", stab_bad, 1'b0);
    check("t5_cnt", byte_cnt, 4'd8);
    check("t5_block", block_out, 128'h707172737475767778797A7B7C7D7E7F);
    check("t5_overrun", overrun_err, 1'b0);

    // 6: asynchronous reset mid-block and during GAP
    send_bytes(8'h90, 1);
    check("t6_cnt9", byte_cnt, 4'd9);
    reset = 1'b0;
    #1;
    check("t6_async_cnt", byte_cnt, 4'd0);
    step();
    reset = 1'b1;
    step();
    send_bytes(8'hB0, 16);
    step();
    check("t6_strobe", write_en, 1'b1);
    step();
    check("t6_gap_pend", pending, 1'b1);
    reset = 1'b0;
    #1;
    check("t6_async_out", {write_en, pending, byte_cnt}, 6'b0);
    check("t6_async_block", block_out, 128'h0);
    step();
    reset = 1'b1;
    step();
    we0 = we_cnt;
    send_bytes(8'hC0, 16);
    check("t6_block", block_out, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    check("t6_pend", pending, 1'b1);
    step();
    check("t6_we", write_en, 1'b1);
    step(6);
    check("t6_we_count", we_cnt - we0, 1);
    check("t6_idle", pending, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
